sram32_lsu_bridge: RTL
======================

// Module: sram32_lsu_bridge
// PURPOSE
//  - Load/store bridge between the core's data-memory request port and one sram32 instance.
//  - Accepts byte, half and word accesses on a valid/ready request channel.
//  - Drives sram32 en/we/adr/din, aligns and sign-extends read data, returns a registered response.
//  - Flags misaligned and out-of-range accesses; these never touch the SRAM.
// PARAMETERS
//  ADDR_BITS  16  byte-address bits decoded by the SRAM (64 KiB); higher bits must be zero
//  ERRW       8   width of the saturating error counter
// PORTS
//  clk        in   1          single clock; all state updates on posedge
//  rst_n      in   1          synchronous, active-low reset
//  req_valid  in   1          request present
//  req_ready  out  1          bridge can accept a request this cycle
//  req_we     in   1          1 = store, 0 = load
//  req_size   in   2          0 = byte, 1 = half, 2 = word, 3 = illegal
//  req_signed in   1          load sign-extends when 1, zero-extends when 0
//  req_adr    in   32         byte address
//  req_wdata  in   32         store data, LSB-justified
//  rsp_valid  out  1          response present
//  rsp_ready  in   1          consumer takes the response
//  rsp_rdata  out  32         load result (0 for stores and errors)
//  rsp_err    out  1          access was misaligned, out of range, or used size 3
//  err_cnt    out  ERRW       saturating count of errored requests
//  mem_en     out  1          to sram32 en
//  mem_we     out  4          to sram32 we (byte lanes)
//  mem_adr    out  32         to sram32 adr
//  mem_din    out  32         to sram32 din
//  mem_dout   in   32         from sram32 dout (combinational read)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, state=IDLE.
//    - mem_en=0 and mem_we=0 while rst_n=0, so reset mid-operation drops any pending response.
//  - FSM states: IDLE (no response held) and RESP (response held).
//    - req_ready = (state==IDLE) | rsp_ready.
//  - Accept = req_valid & req_ready.
//    - On accept, next state = RESP; otherwise, if rsp_ready, next state = IDLE.
//    - Accept and rsp_ready in the same cycle stay in RESP and load the new response.
//    - This gives back-to-back throughput of one access per cycle.
//  - Latency: the response is visible the cycle after accept.
//    - It holds stable while rsp_valid & !rsp_ready.
//  - Error detection (combinational on the request):
//    - misaligned: size==1 and adr[0]; or size==2 and adr[1:0]!=0.
//    - out of range: adr[31:ADDR_BITS]!=0.
//    - illegal size: size==3.
//  - SRAM drive, combinational:
//    - mem_en = accept & !err.
//    - mem_adr = req_adr.
//    - Erroring requests get mem_en=0 and mem_we=0.
//  - Stores:
//    - mem_we: byte = 4'b0001<<adr[1:0]; half = 4'b0011<<{adr[1],1'b0}; word = 4'hF; gated by mem_en.
//    - mem_din: byte lane replicated 4x, half replicated 2x, word passed through.
//    - The SRAM commits at the same posedge that accepts the request.
//  - Loads:
//    - Select the lane from mem_dout by adr[1:0] and size.
//    - Extend to 32 bits per req_signed.
//    - Register the result into rsp_rdata at the accept edge.
//    - Store-then-load to the same word on consecutive cycles returns the new data; no hazard logic.
//  - err_cnt increments on every accepted errored request and saturates at all-ones.
// STRUCTURE
//  - Shared package sram32_pkg:
//    - SZ_BYTE/SZ_HALF/SZ_WORD localparams.
//    - state encoding IDLE/RESP.
//    - function be_gen(size, adr_lo) -> [3:0].
//  - One sub-module, sram32_load_align: combinational lane select and sign/zero extend.
//    - Inputs: dout, adr_lo, size, signed.
//    - Output: 32-bit value.
//  - Everything else stays in the top.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> rsp_valid=0, err_cnt=0, mem_we=0 throughout.
//  - Byte store at 0x0003, wdata 0xAB:
//    - required: mem_we=4'b1000, mem_din=0xABABABAB.
//    - then a signed byte load at 0x0003 -> rsp_rdata=0xFFFFFFAB.
//    - the same load unsigned -> 0x000000AB.
//  - Word store 0x12345678 at 0x0100, then a half load at 0x0102 on the next cycle:
//    - required: rsp_rdata=0x00001234.
//    - a signed half load of 0x8000 -> 0xFFFF8000.
//  - Half load at 0x0001 -> rsp_err=1, rsp_rdata=0, mem_en=0, err_cnt increments.
//  - Load at 0x0001_0000 -> rsp_err=1, err_cnt increments.
//  - Back-pressure: 4 back-to-back loads with rsp_ready low on cycles 2-3:
//    - req_ready=0 while a response is held and rsp_ready is low.
//    - responses arrive in order with rdata stable while stalled.
//    - the stream returns to one per cycle once rsp_ready=1.
//  - Error counter saturation: 260 errored requests with ERRW=8 -> err_cnt=0xFF, no wrap.

Source files
------------

// File: rtl/sram32_pkg.sv
// Shared definitions for the sram32 load/store bridge.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size encodings (3 is illegal)
//   state_t                 : bridge response FSM encoding
//   be_gen()                : byte-lane enables for a store of a given size/offset
package sram32_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] adr_lo);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << adr_lo;
            SZ_HALF: be_gen = 4'b0011 << {adr_lo[1], 1'b0};
            SZ_WORD: be_gen = 4'hF;
            default: be_gen = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/sram32_lsu_bridge_if.sv
// Core-side request/response channel of the sram32 load/store bridge.
//   req_*  : valid/ready request (we, size, signed, byte address, store data)
//   rsp_*  : valid/ready response (load data, error flag)
// master = core side, slave = bridge side.
interface sram32_lsu_bridge_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_adr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_adr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram32_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the SRAM
// word and sign- or zero-extends it to 32 bits.
//   dout      in  32  raw SRAM read word
//   adr_lo    in  2   byte offset within the word
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_signed in  1   1 = sign-extend, 0 = zero-extend
//   value     out 32  aligned, extended load result
module sram32_load_align
    import sram32_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  adr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = dout[{adr_lo, 3'b000} +: 8];
        lane_h = adr_lo[1] ? dout[31:16] : dout[15:0];
        case (size)
            SZ_BYTE: value = {{24{is_signed & lane_b[7]}}, lane_b};
            SZ_HALF: value = {{16{is_signed & lane_h[15]}}, lane_h};
            default: value = dout;
        endcase
    end

endmodule

// File: rtl/sram32_lsu_bridge.sv
// Load/store bridge between the core data-memory port and one sram32.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/response channel (slave side)
//   err_cnt    : saturating count of errored requests
//   mem_*      : sram32 en/we/adr/din, mem_dout is its combinational read data
//
// state | meaning
// IDLE  | no response held, always ready for a request
// RESP  | response held on rsp_*, ready only if the consumer takes it this cycle
module sram32_lsu_bridge
    import sram32_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int ERRW      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sram32_lsu_bridge_if.slave bus,
    output logic [ERRW-1:0]   err_cnt,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_adr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    state_t      state;
    state_t      state_n;
    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_value;

    always_comb begin
        misaligned   = (bus.req_size == SZ_HALF && bus.req_adr[0]) ||
                       (bus.req_size == SZ_WORD && bus.req_adr[1:0] != 2'b00);
        out_of_range = (bus.req_adr >> ADDR_BITS) != 32'd0;
        req_err      = misaligned | out_of_range | (bus.req_size == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // accept is masked by rst_n so nothing reaches the SRAM while in reset
    always_comb begin
        state_n       = state;
        bus.req_ready = (state == IDLE) | bus.rsp_ready;
        bus.rsp_valid = (state == RESP);
        accept        = bus.req_valid & bus.req_ready & rst_n;
        if (accept) begin
            state_n = RESP;
        end else if (bus.rsp_ready) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        mem_en  = accept & ~req_err;
        mem_we  = be_gen(bus.req_size, bus.req_adr[1:0]) & {4{mem_en & bus.req_we}};
        mem_adr = bus.req_adr;
        case (bus.req_size)
            SZ_BYTE: mem_din = {4{bus.req_wdata[7:0]}};
            SZ_HALF: mem_din = {2{bus.req_wdata[15:0]}};
            default: mem_din = bus.req_wdata;
        endcase
    end

    sram32_load_align u_align (
        .dout      (mem_dout),
        .adr_lo    (bus.req_adr[1:0]),
        .size      (bus.req_size),
        .is_signed (bus.req_signed),
        .value     (load_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            err_cnt       <= '0;
        end else if (accept) begin
            bus.rsp_err   <= req_err;
            bus.rsp_rdata <= (req_err | bus.req_we) ? 32'd0 : load_value;
            if (req_err && err_cnt != {ERRW{1'b1}}) begin
                err_cnt <= err_cnt + {{(ERRW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
